// File: rtl/diff_window_acc.sv
// Sliding horizontal window sum of green-difference samples with a strict threshold flag.
// Optional DIFF_WIN_EDGE_EN: emit partial sums during row fill and expose out_full.
module diff_window_acc #(
  parameter int unsigned pixelBitWidth = 14,
  parameter int unsigned WIN           = 5,
  parameter int unsigned SUM_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sol,
  input  logic [pixelBitWidth-2:0]   in_diff,
  input  logic [SUM_W-1:0]           threshold,
  output logic                       out_valid,
  output logic [SUM_W-1:0]           out_sum,
  output logic                       out_flag,
`ifdef DIFF_WIN_EDGE_EN
  output logic                       out_full,
`endif
  output logic                       out_sol
);

  localparam int unsigned DIFF_W = pixelBitWidth - 1;
  localparam int unsigned CNT_W  = $clog2(WIN + 1);

  logic [DIFF_W-1:0] win_q [WIN];
  logic [DIFF_W-1:0] win_d [WIN];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              mark_q, mark_d;
  logic              out_valid_q, out_valid_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic              out_flag_q, out_flag_d;
  logic              out_sol_q, out_sol_d;
  logic              full_c;
  logic              emit_c;
`ifdef DIFF_WIN_EDGE_EN
  logic              out_full_q, out_full_d;
`endif

  // Window update, fill tracking and output gating for one accepted sample
  always_comb begin
    win_d       = win_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    mark_d      = mark_q;
    out_valid_d = 1'b0;
    out_sum_d   = out_sum_q;
    out_flag_d  = out_flag_q;
    out_sol_d   = out_sol_q;
    full_c      = 1'b0;
    emit_c      = 1'b0;
`ifdef DIFF_WIN_EDGE_EN
    out_full_d  = out_full_q;
`endif
    if (in_valid) begin
      if (in_sol) begin
        for (int i = 0; i < WIN; i++) win_d[i] = '0;
        win_d[0] = in_diff;
        sum_d    = SUM_W'(in_diff);
        fill_d   = CNT_W'(1);
        mark_d   = 1'b1;
      end else begin
        win_d[0] = in_diff;
        for (int i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
        // Exact: sum always contains the oldest entry, so the subtraction cannot underflow
        sum_d = sum_q + SUM_W'(in_diff) - SUM_W'(win_q[WIN-1]);
        if (fill_q != CNT_W'(WIN)) fill_d = fill_q + CNT_W'(1);
      end
      full_c = (fill_d == CNT_W'(WIN));
`ifdef DIFF_WIN_EDGE_EN
      emit_c     = 1'b1;
      out_full_d = full_c;
`else
      emit_c     = full_c;
`endif
      if (emit_c) begin
        out_valid_d = 1'b1;
        out_sum_d   = sum_d;
        out_flag_d  = (sum_d > threshold);
        out_sol_d   = mark_d;
        mark_d      = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      mark_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_flag_q  <= 1'b0;
      out_sol_q   <= 1'b0;
`ifdef DIFF_WIN_EDGE_EN
      out_full_q  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < WIN; i++) win_q[i] <= win_d[i];
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      mark_q      <= mark_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_flag_q  <= out_flag_d;
      out_sol_q   <= out_sol_d;
`ifdef DIFF_WIN_EDGE_EN
      out_full_q  <= out_full_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_flag  = out_flag_q;
  assign out_sol   = out_sol_q;
`ifdef DIFF_WIN_EDGE_EN
  assign out_full  = out_full_q;
`endif

endmodule

// File: tb/tb_diff_window_acc.sv
// Directed self-checking bench for diff_window_acc (WIN=5, SUM_W=16).
module tb_diff_window_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_sol;
  logic [12:0] in_diff;
  logic [15:0] threshold;
  logic        out_valid;
  logic [15:0] out_sum;
  logic        out_flag;
  logic        out_sol;
`ifdef DIFF_WIN_EDGE_EN
  logic        out_full;
`endif

  int n_cmp;
  int n_err;

  diff_window_acc #(.pixelBitWidth(14), .WIN(5), .SUM_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sol    (in_sol),
    .in_diff   (in_diff),
    .threshold (threshold),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_flag  (out_flag),
`ifdef DIFF_WIN_EDGE_EN
    .out_full  (out_full),
`endif
    .out_sol   (out_sol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted sample; returns #1 after the capturing edge
  task automatic send(input logic sol, input logic [12:0] d, input logic [15:0] thr);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sol    = sol;
    in_diff   = d;
    threshold = thr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sol    = 1'b0;
  endtask

  task automatic idle_chk(input int n, input logic [15:0] held);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("gap_valid", 32'(out_valid), 32'd0);
      chk("gap_hold", 32'(out_sum), 32'(held));
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sol    = 1'b0;
    in_diff   = '0;
    threshold = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_flag", 32'(out_flag), 32'd0);
    chk("rst_sol", 32'(out_sol), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef DIFF_WIN_EDGE_EN
    send(1'b1, 13'd1, 16'd0);
    chk("e1_valid", 32'(out_valid), 32'd1);
    chk("e1_sum", 32'(out_sum), 32'd1);
    chk("e1_sol", 32'(out_sol), 32'd1);
    chk("e1_full", 32'(out_full), 32'd0);
    send(1'b0, 13'd2, 16'd0);
    chk("e2_sum", 32'(out_sum), 32'd3);
    chk("e2_sol", 32'(out_sol), 32'd0);
    send(1'b0, 13'd3, 16'd0);
    send(1'b0, 13'd4, 16'd0);
    chk("e4_valid", 32'(out_valid), 32'd1);
    chk("e4_sum", 32'(out_sum), 32'd10);
    chk("e4_full", 32'(out_full), 32'd0);
    send(1'b0, 13'd5, 16'd0);
    chk("e5_sum", 32'(out_sum), 32'd15);
    chk("e5_full", 32'(out_full), 32'd1);
    chk("e5_flag", 32'(out_flag), 32'd1);
`else
    // Fill: four silent samples then first full window
    send(1'b1, 13'd1, 16'd100);
    chk("fill1_valid", 32'(out_valid), 32'd0);
    send(1'b0, 13'd2, 16'd100);
    chk("fill2_valid", 32'(out_valid), 32'd0);
    send(1'b0, 13'd3, 16'd100);
    chk("fill3_valid", 32'(out_valid), 32'd0);
    send(1'b0, 13'd4, 16'd100);
    chk("fill4_valid", 32'(out_valid), 32'd0);
    send(1'b0, 13'd5, 16'd100);
    chk("fill5_valid", 32'(out_valid), 32'd1);
    chk("fill5_sum", 32'(out_sum), 32'd15);
    chk("fill5_sol", 32'(out_sol), 32'd1);
    chk("fill5_flag", 32'(out_flag), 32'd0);

    // Slide: sum equal to threshold is not flagged
    send(1'b0, 13'd6, 16'd20);
    chk("slide6_sum", 32'(out_sum), 32'd20);
    chk("slide6_flag", 32'(out_flag), 32'd0);
    chk("slide6_sol", 32'(out_sol), 32'd0);
    send(1'b0, 13'd7, 16'd20);
    chk("slide7_sum", 32'(out_sum), 32'd25);
    chk("slide7_flag", 32'(out_flag), 32'd1);
    chk("slide7_sol", 32'(out_sol), 32'd0);

    // Gaps between samples
    idle_chk(3, 16'd25);
    send(1'b0, 13'd8, 16'd20);
    chk("gap8_valid", 32'(out_valid), 32'd1);
    chk("gap8_sum", 32'(out_sum), 32'd30);
    chk("gap8_flag", 32'(out_flag), 32'd1);
    idle_chk(3, 16'd30);
    send(1'b0, 13'd9, 16'd50);
    chk("gap9_sum", 32'(out_sum), 32'd35);
    chk("gap9_flag", 32'(out_flag), 32'd0);

    // Line restart purges the old row
    send(1'b1, 13'd7, 16'd0);
    chk("rs1_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 13'd0, 16'd0);
      chk("rs_fill_valid", 32'(out_valid), 32'd0);
    end
    send(1'b0, 13'd0, 16'd0);
    chk("rs5_valid", 32'(out_valid), 32'd1);
    chk("rs5_sum", 32'(out_sum), 32'd7);
    chk("rs5_sol", 32'(out_sol), 32'd1);
    chk("rs5_flag", 32'(out_flag), 32'd1);

    // Maximum sample values
    send(1'b1, 13'd8191, 16'd40000);
    for (int i = 0; i < 4; i++) send(1'b0, 13'd8191, 16'd40000);
    chk("sat_valid", 32'(out_valid), 32'd1);
    chk("sat_sum", 32'(out_sum), 32'd40955);
    chk("sat_flag", 32'(out_flag), 32'd1);
    send(1'b0, 13'd0, 16'd40000);
    chk("sat_drop_sum", 32'(out_sum), 32'd32764);
    chk("sat_drop_flag", 32'(out_flag), 32'd0);

    // One-pixel rows never emit; following row fills from its last in_sol
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 13'd5, 16'd0);
      chk("b2b_valid", 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 13'd1, 16'd0);
      chk("b2b_fill_valid", 32'(out_valid), 32'd0);
    end
    send(1'b0, 13'd1, 16'd0);
    chk("b2b_out_valid", 32'(out_valid), 32'd1);
    chk("b2b_sum", 32'(out_sum), 32'd9);
    chk("b2b_sol", 32'(out_sol), 32'd1);

    // Asynchronous reset mid-row
    send(1'b1, 13'd10, 16'd45);
    send(1'b0, 13'd10, 16'd45);
    send(1'b0, 13'd10, 16'd45);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sum", 32'(out_sum), 32'd0);
    chk("arst_flag", 32'(out_flag), 32'd0);
    chk("arst_sol", 32'(out_sol), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(1'b1, 13'd10, 16'd45);
    chk("post1_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 13'd10, 16'd45);
      chk("post_fill_valid", 32'(out_valid), 32'd0);
    end
    send(1'b0, 13'd10, 16'd45);
    chk("post5_valid", 32'(out_valid), 32'd1);
    chk("post5_sum", 32'(out_sum), 32'd50);
    chk("post5_flag", 32'(out_flag), 32'd1);
    chk("post5_sol", 32'(out_sol), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/diff_window_acc.md
Name: diff_window_acc

Overview:
- Downstream of the green-difference stage. Consumes the streamed 13-bit absolute green_h/green_v difference, one per valid pixel.
- Keeps a sliding horizontal window sum over WIN consecutive pixels of the current row.
- Compares the sum against a programmable threshold, producing the per-pixel gradient-strength flag used by the interpolation-direction decision.
- Streaming only: no backpressure.

Parameters:
- pixelBitWidth, 14, raw pixel width; the input difference is pixelBitWidth-1 bits.
- WIN, 5, window length in pixels; legal range 2..16.
- SUM_W, 16, sum/threshold width; must be at least (pixelBitWidth-1)+ceil(log2(WIN)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_diff/in_sol qualify this cycle.
- in_sol  input  1  start of line; first pixel of a new row (meaningful only with in_valid).
- in_diff  input  pixelBitWidth-1  absolute difference sample, unsigned.
- threshold  input  SUM_W  compare level; sampled every accepted cycle.
- out_valid  output  1  out_sum/out_flag/out_sol valid this cycle.
- out_sum  output  SUM_W  sum of the last WIN accepted samples of the current row.
- out_flag  output  1  1 when out_sum > threshold (strict).
- out_sol  output  1  first output of a row.

Behaviour:
- Reset (async, immediate): all outputs 0. Window shift register cleared to 0. Running sum 0. Fill counter 0. first-of-row marker 0.
- Accepted sample: a rising edge with in_valid=1. Edges with in_valid=0 hold all state; out_valid drops to 0 and out_sum/out_flag/out_sol hold their last values.
- Window: WIN-entry shift register, entry 0 newest.
  - On accept: new sample enters entry 0 and entry WIN-1 is discarded.
  - sum_next = sum + in_diff - oldest, where oldest = entry WIN-1. This is exact unsigned arithmetic: sum never goes negative or overflows for legal SUM_W.
- in_sol on an accepted cycle:
  - Window contents are treated as zero: all entries cleared except entry 0, which takes in_diff.
  - sum_next = in_diff.
  - Fill counter = 1. first-of-row marker set.
- Fill counter increments per accepted sample and saturates at WIN.
- Output gating:
  - out_valid=1 on the edge after an accepted sample only if the post-update fill counter equals WIN. A row's first WIN-1 samples produce no output.
  - out_sol=1 on the first out_valid after an in_sol; the marker then clears.
  - A row shorter than WIN produces no outputs; the marker is cleared by the next in_sol.
- Latency: 1 cycle, accepted sample to registered outputs. out_sum = sum_next. out_flag = (sum_next > threshold), using threshold at the accept edge.
- Back-to-back in_sol (one-pixel rows): each restarts the fill; no output.
- Samples before the first in_sol after reset accumulate as a row start with fill from 0.
- Reset mid-window: in-flight window discarded; the next row needs a full WIN-sample fill.

Optional Feature:
- Macro DIFF_WIN_EDGE_EN.
- Defined:
  - out_valid is asserted for every accepted sample, including fill-phase samples.
  - out_sum is the partial sum of the samples so far in the row.
  - out_flag compares that partial sum.
  - out_sol marks the very first sample of the row.
  - Adds output port out_full (1 bit, reset 0), which is 1 when the fill counter equals WIN.
- Not defined: behaviour exactly as above; no out_full port.

Test Plan:
- Fill (WIN=5, threshold=100): in_sol with 1, then 2,3,4,5 back-to-back.
  - out_valid low for the first four outputs.
  - Edge after the 5th sample: out_valid=1, out_sum=15, out_sol=1, out_flag=0.
- Slide and threshold:
  - Continue with 6, threshold=20: out_sum=20, out_flag=0.
  - Then 7, threshold=20: out_sum=25, out_flag=1, out_sol=0.
- Gaps: insert 3 idle cycles between samples.
  - out_valid low during the gaps.
  - Sums identical to the gap-free run; out_sum holds its value.
- Line restart: mid-row, in_sol with 7, then 0,0,0,0.
  - No output for 4 samples.
  - Then out_valid=1, out_sum=7, out_sol=1 (old row fully purged).
- Saturation width: in_sol then five samples of 8191 → out_sum=40955. Next sample 0 → out_sum=32764.
- Async reset mid-row (after 3 samples): outputs 0 immediately without a clock edge. Five new in_sol-started samples of 10 → out_sum=50 on the fifth only.
- With DIFF_WIN_EDGE_EN: first sample 1 → out_valid=1, out_sum=1, out_full=0. Fifth sample → out_full=1.
